siso_phase_sequencer: RTL and testbench

Sequencer for the latch-based SISO shift chains (slice, 4x4 and 4x4x4 tranches). It accepts one 4-bit nibble per valid/ready handshake and holds it on the chain input. It then issues the four sequential, non-overlapping latch pulses (latch[0] first, latch[3] last) that advance the chain by one nibble, and captures the chain output. It also tracks fill level so it only flags output nibbles that are real data.

---
 rtl/siso_phase_sequencer.sv | 171 +++++++++++++++++
 tb/tb_siso_phase_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_phase_sequencer.sv
// -----------------------------------------------------------------------------
// siso_phase_sequencer
//
// Drives a latch-based SISO shift chain (slice, 4x4 or 4x4x4 tranche). One
// nibble is accepted per valid/ready handshake and held on siso_in. The chain
// is then advanced by one nibble with four sequential, non-overlapping latch
// pulses (latch[0] first, latch[3] last), each surrounded by idle gaps. The
// chain output is captured after the last gap. A saturating fill counter makes
// sure out_valid is only raised once real data has reached the chain output.
//
// Sequence after acceptance:
//   GAP(0) PULSE(0) GAP(1) PULSE(1) GAP(2) PULSE(2) GAP(3) PULSE(3) GAP(4) DONE
//   busy length = 5*GAP_CYC + 4*PULSE_CYC + 1 cycles
//
// Parameters:
//   PULSE_CYC  cycles each latch pulse is active (1..15)
//   GAP_CYC    idle cycles before each pulse and after the last (1..15)
//   DEPTH      shift operations for an accepted nibble to reach siso_out (1..255)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   nibble offered
//   in_data    nibble to shift in
//   in_ready   sequencer idle, can accept
//   out_valid  one-cycle strobe, out_data holds real data
//   out_data   nibble captured from the chain
//   siso_in    registered chain data input
//   siso_out   chain data output
//   latch      chain pass/keep pulses, each bit a flop output
//   busy       shift sequence in progress (!in_ready)
//
// Build option:
//   SISO_LATCH_INVERT_EN  when defined, latch idles high and pulses low
//                         (reset value 4'b1111); timing is unchanged.
// -----------------------------------------------------------------------------
module siso_phase_sequencer #(
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 1,
    parameter int DEPTH     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic [3:0] siso_in,
    input  logic [3:0] siso_out,
    output logic [3:0] latch,
    output logic       busy
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(DEPTH);
    localparam logic [3:0]        GAP_LOAD   = 4'(GAP_CYC - 1);
    localparam logic [3:0]        PULSE_LOAD = 4'(PULSE_CYC - 1);
    localparam logic [2:0]        LAST_GAP   = 3'd4;

`ifdef SISO_LATCH_INVERT_EN
    localparam logic [3:0] LATCH_IDLE = 4'b1111;
`else
    localparam logic [3:0] LATCH_IDLE = 4'b0000;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_PULSE,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        phase;
    logic [2:0]        phase_nxt;
    logic [3:0]        timer;
    logic [3:0]        timer_nxt;
    logic [3:0]        latch_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;
    logic              accept;
    logic              capture;

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid && in_ready;

    // Chain output is sampled on the edge that leaves the final gap.
    assign capture  = (state == ST_GAP) && (timer == 4'd0) && (phase == LAST_GAP);

    // Fill level never wraps; once the chain is full every op yields data.
    assign fill_inc = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        timer_nxt = timer;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_GAP;
                    phase_nxt = 3'd0;
                    timer_nxt = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (timer == 4'd0) begin
                    if (phase == LAST_GAP) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_PULSE;
                        timer_nxt = PULSE_LOAD;
                    end
                end else begin
                    timer_nxt = timer - 4'd1;
                end
            end
            ST_PULSE: begin
                if (timer == 4'd0) begin
                    state_nxt = ST_GAP;
                    phase_nxt = phase + 3'd1;
                    timer_nxt = GAP_LOAD;
                end else begin
                    timer_nxt = timer - 4'd1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Latch levels are decoded from the next state so each bit is a
        // plain flop output with no decode glitches on the chain.
        latch_nxt = LATCH_IDLE;
        if (state_nxt == ST_PULSE) begin
            latch_nxt = LATCH_IDLE ^ (4'b0001 << phase_nxt[1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= 3'd0;
            timer     <= 4'd0;
            latch     <= LATCH_IDLE;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            siso_in   <= 4'd0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            timer     <= timer_nxt;
            latch     <= latch_nxt;
            out_valid <= capture && (fill_inc == FILL_MAX);
            if (accept) begin
                siso_in <= in_data;
            end
            if (capture) begin
                out_data <= siso_out;
                fill     <= fill_inc;
            end
        end
    end

endmodule

// File: tb/tb_siso_phase_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for siso_phase_sequencer. A default instance is connected to a
// behavioural chain model (DEPTH nibble stages, advanced once per op by the
// latch[3] pulse); a second instance with PULSE_CYC=3, GAP_CYC=2 checks the
// stretched pulse timing. Expected output nibbles are pushed to a scoreboard
// queue at acceptance and popped when the DONE cycle is observed.
// -----------------------------------------------------------------------------
module tb_siso_phase_sequencer;

    localparam int P1 = 1;
    localparam int G1 = 1;
    localparam int D1 = 3;
    localparam int N1 = 5 * G1 + 4 * P1 + 1;
    localparam int P2 = 3;
    localparam int G2 = 2;
    localparam int D2 = 3;
    localparam int N2 = 5 * G2 + 4 * P2 + 1;

`ifdef SISO_LATCH_INVERT_EN
    localparam logic [3:0] IDLE_LAT = 4'hF;
`else
    localparam logic [3:0] IDLE_LAT = 4'h0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [3:0] siso_in;
    logic [3:0] siso_out;
    logic [3:0] latch;
    logic       busy;

    logic       in_valid2;
    logic [3:0] in_data2;
    logic       in_ready2;
    logic       out_valid2;
    logic [3:0] out_data2;
    logic [3:0] siso_in2;
    logic [3:0] siso_out2;
    logic [3:0] latch2;
    logic       busy2;

    siso_phase_sequencer #(.PULSE_CYC(P1), .GAP_CYC(G1), .DEPTH(D1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .siso_in(siso_in), .siso_out(siso_out), .latch(latch), .busy(busy)
    );

    siso_phase_sequencer #(.PULSE_CYC(P2), .GAP_CYC(G2), .DEPTH(D2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .siso_in(siso_in2), .siso_out(siso_out2), .latch(latch2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural chain: one nibble shift per op, triggered by the first
    // cycle of the latch[3] pulse.
    logic [11:0] chain   = 12'h000;
    logic        l3_prev = 1'b0;
    logic [3:0]  act;
    assign act      = latch ^ IDLE_LAT;
    assign siso_out = chain[11:8];
    assign siso_out2 = 4'h0;

    always @(posedge clk) begin
        l3_prev <= act[3];
        if (act[3] && !l3_prev) chain <= {chain[7:0], siso_in};
    end

    // Scoreboard state
    logic [3:0] sent_q[$];
    logic [3:0] exp_q[$];
    int         tb_fill = 0;
    logic       exp_v;
    int         acc_cyc;

    // Per-op trace, index 0 = first cycle after acceptance
    logic [3:0] tr_latch[64];
    logic       tr_ready[64];
    logic       tr_busy[64];
    logic       tr_ov[64];
    logic [3:0] tr_od[64];
    logic [3:0] tr_siso[64];

    function automatic logic [3:0] exp_pat(int c, int p, int g);
        int t;
        t = c;
        for (int k = 0; k < 4; k++) begin
            if (t < g) return 4'h0;
            t -= g;
            if (t < p) return 4'b0001 << k;
            t -= p;
        end
        return 4'h0;
    endfunction

    task automatic clear_board();
        sent_q.delete();
        exp_q.delete();
        tb_fill = 0;
    endtask

    task automatic do_op(input logic [3:0] d, input bit hold);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        acc_cyc = cyc;
        sent_q.push_back(d);
        if (tb_fill < D1) tb_fill++;
        exp_v = (tb_fill == D1);
        if (exp_v) exp_q.push_back(sent_q[sent_q.size() - D1]);
        if (!hold) in_valid = 1'b0;
        for (int c = 0; c <= N1; c++) begin
            tr_latch[c] = latch;
            tr_ready[c] = in_ready;
            tr_busy[c]  = busy;
            tr_ov[c]    = out_valid;
            tr_od[c]    = out_data;
            tr_siso[c]  = siso_in;
            if (c < N1) begin
                if (hold) in_data = ~d ^ 4'(c);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (latch !== IDLE_LAT) begin n_fail++; $display("FAIL rst_latch: got %h required %h", latch, IDLE_LAT); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_checks++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL rst_out_data: got %h required 0", out_data); end
        n_checks++; if (siso_in !== 4'h0) begin n_fail++; $display("FAIL rst_siso_in: got %h required 0", siso_in); end
        n_checks++; if (latch2 !== IDLE_LAT) begin n_fail++; $display("FAIL rst_latch2: got %h required %h", latch2, IDLE_LAT); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_op();
        int low;
        do_op(4'hA, 1'b0);
        n_checks++; if (tr_siso[0] !== 4'hA) begin n_fail++; $display("FAIL single_siso_in: got %h required a", tr_siso[0]); end
        low = 0;
        for (int c = 0; c <= N1; c++) begin
            n_checks++;
            if (tr_latch[c] !== (exp_pat(c, P1, G1) ^ IDLE_LAT)) begin
                n_fail++;
                $display("FAIL single_latch c=%0d: got %h required %h", c, tr_latch[c], exp_pat(c, P1, G1) ^ IDLE_LAT);
            end
            n_checks++;
            if (tr_busy[c] !== ~tr_ready[c]) begin
                n_fail++;
                $display("FAIL single_busy c=%0d: busy=%b in_ready=%b", c, tr_busy[c], tr_ready[c]);
            end
            if (tr_ready[c] === 1'b0) low++;
        end
        n_checks++; if (low != 10) begin n_fail++; $display("FAIL single_busy_len: got %0d required 10", low); end
        n_checks++; if (tr_ready[N1] !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b required 1", tr_ready[N1]); end
        n_checks++; if (tr_ov[N1-1] !== exp_v) begin n_fail++; $display("FAIL single_out_valid: got %b required %b", tr_ov[N1-1], exp_v); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_data  = 4'h5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (latch !== (4'h4 ^ IDLE_LAT)) begin n_fail++; $display("FAIL mid_pulse2: got %h required %h", latch, 4'h4 ^ IDLE_LAT); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (latch !== IDLE_LAT) begin n_fail++; $display("FAIL mid_async_latch: got %h required %h", latch, IDLE_LAT); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_ready: got %b required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_ov: got %b required 0", out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_board();
        do_op(4'h6, 1'b0);
        n_checks++; if (tr_latch[0] !== IDLE_LAT) begin n_fail++; $display("FAIL mid_restart_gap0: got %h required %h", tr_latch[0], IDLE_LAT); end
        n_checks++; if (tr_latch[1] !== (4'h1 ^ IDLE_LAT)) begin n_fail++; $display("FAIL mid_restart_pulse0: got %h required %h", tr_latch[1], 4'h1 ^ IDLE_LAT); end
        n_checks++; if (tr_ov[N1-1] !== exp_v) begin n_fail++; $display("FAIL mid_restart_ov: got %b required %b", tr_ov[N1-1], exp_v); end
    endtask

    task automatic test_chain();
        logic [3:0] e;
        logic [3:0] stream [4];
        stream = '{4'h1, 4'h2, 4'h3, 4'h4};
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_board();
        for (int i = 0; i < 4; i++) begin
            do_op(stream[i], 1'b0);
            n_checks++;
            if (tr_ov[N1-1] !== exp_v) begin
                n_fail++;
                $display("FAIL chain_ov op%0d: got %b required %b", i + 1, tr_ov[N1-1], exp_v);
            end
            n_checks++;
            if (tr_ov[N1-2] !== 1'b0 || tr_ov[N1] !== 1'b0) begin
                n_fail++;
                $display("FAIL chain_strobe op%0d: before=%b after=%b required 0", i + 1, tr_ov[N1-2], tr_ov[N1]);
            end
            if (exp_v && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (tr_od[N1-1] !== e) begin
                    n_fail++;
                    $display("FAIL chain_data op%0d: got %h required %h", i + 1, tr_od[N1-1], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_acc;
        logic [3:0] e;
        do_op(4'h7, 1'b1);
        first_acc = acc_cyc;
        for (int c = 0; c <= N1; c++) begin
            n_checks++;
            if (tr_siso[c] !== 4'h7) begin
                n_fail++;
                $display("FAIL b2b_siso_stable c=%0d: got %h required 7", c, tr_siso[c]);
            end
        end
        n_checks++; if (tr_ov[N1-1] !== exp_v) begin n_fail++; $display("FAIL b2b_ov1: got %b required %b", tr_ov[N1-1], exp_v); end
        if (exp_v && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (tr_od[N1-1] !== e) begin n_fail++; $display("FAIL b2b_data1: got %h required %h", tr_od[N1-1], e); end
        end
        do_op(4'h8, 1'b0);
        n_checks++; if (acc_cyc - first_acc != N1 + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d required %0d", acc_cyc - first_acc, N1 + 1); end
        n_checks++; if (tr_siso[0] !== 4'h8) begin n_fail++; $display("FAIL b2b_siso2: got %h required 8", tr_siso[0]); end
        n_checks++; if (tr_ov[N1-1] !== exp_v) begin n_fail++; $display("FAIL b2b_ov2: got %b required %b", tr_ov[N1-1], exp_v); end
        if (exp_v && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (tr_od[N1-1] !== e) begin n_fail++; $display("FAIL b2b_data2: got %h required %h", tr_od[N1-1], e); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_board_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_timing();
        int w;
        int low;
        w = 0;
        while (!in_ready2 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid2 = 1'b1;
        in_data2  = 4'h9;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        low = 0;
        for (int c = 0; c <= N2; c++) begin
            n_checks++;
            if (latch2 !== (exp_pat(c, P2, G2) ^ IDLE_LAT)) begin
                n_fail++;
                $display("FAIL timing_latch c=%0d: got %h required %h", c, latch2, exp_pat(c, P2, G2) ^ IDLE_LAT);
            end
            n_checks++;
            if ($countones(latch2 ^ IDLE_LAT) > 1) begin
                n_fail++;
                $display("FAIL timing_overlap c=%0d: got %h", c, latch2);
            end
            n_checks++;
            if (out_valid2 !== 1'b0) begin
                n_fail++;
                $display("FAIL timing_ov c=%0d: got %b required 0", c, out_valid2);
            end
            if (in_ready2 === 1'b0) low++;
            if (c < N2) begin
                @(posedge clk); #1;
            end
        end
        n_checks++; if (low != N2) begin n_fail++; $display("FAIL timing_busy_len: got %0d required %0d", low, N2); end
        n_checks++; if (siso_in2 !== 4'h9) begin n_fail++; $display("FAIL timing_siso_in: got %h required 9", siso_in2); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_valid2 = 1'b0;
        in_data2  = 4'h0;
        test_reset();
        test_single_op();
        test_reset_mid();
        test_chain();
        test_back_to_back();
        test_timing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
